// File: rtl/branch_target_unit.sv
// branch_target_unit
//   Program-counter stage with a runtime-writable branch target table.
//   Each of the 2**A table entries holds a D-bit target plus a mode bit
//   (absolute address, or signed offset added to the current PC) and a
//   valid bit. A branch indexes the table combinationally and loads the
//   next PC on the following edge; otherwise the PC increments or holds.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr   table write strobe and entry index
//   wr_target       target value (offset or absolute address)
//   wr_abs          entry mode: 1 = absolute, 0 = relative
//   stall           hold pc this cycle (branch ignored)
//   branch/lut_addr take a branch through table entry lut_addr
//   pc              registered program counter
//   taken           1 for the cycle after a branch was applied
//   err             1 for the cycle after a branch hit an unwritten entry

// One table entry. Only the valid bit is reset; target and mode are plain
// storage that is meaningless until the first write sets valid.
module branch_target_entry #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [D-1:0] wr_target,
    input  logic         wr_abs,
    output logic [D-1:0] target,
    output logic         abs,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  valid <= 1'b0;
        else if (we) valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            target <= wr_target;
            abs    <= wr_abs;
        end
    end

endmodule

module branch_target_unit #(
    parameter int D = 12,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_target,
    input  logic         wr_abs,
    input  logic         stall,
    input  logic         branch,
    input  logic [A-1:0] lut_addr,
    output logic [D-1:0] pc,
    output logic         taken,
    output logic         err
);

    localparam int DEPTH = 2 ** A;

    typedef struct packed {
        logic [D-1:0] target;
        logic         abs;
        logic         valid;
    } entry_t;

    logic [DEPTH-1:0][D-1:0] entry_target;
    logic [DEPTH-1:0]        entry_abs;
    logic [DEPTH-1:0]        entry_valid;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            branch_target_entry #(.D(D)) u_entry (
                .clk       (clk),
                .rst_n     (rst_n),
                .we        (wr_en && (wr_addr == A'(i))),
                .wr_target (wr_target),
                .wr_abs    (wr_abs),
                .target    (entry_target[i]),
                .abs       (entry_abs[i]),
                .valid     (entry_valid[i])
            );
        end
    endgenerate

    // Combinational read of the current register contents: a write on the
    // same edge lands after this value is consumed (read-before-write).
    entry_t rd;
    always_comb begin
        rd.target = entry_target[lut_addr];
        rd.abs    = entry_abs[lut_addr];
        rd.valid  = entry_valid[lut_addr];
    end

    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_rel;
    logic [D-1:0] next_pc;
    logic         next_taken;
    logic         next_err;

    // D-bit adds; carry-out dropped. A relative target is two's complement,
    // so a plain modular add covers negative offsets too.
    assign pc_inc = pc + {{(D-1){1'b0}}, 1'b1};
    assign pc_rel = pc + rd.target;

    always_comb begin
        next_pc    = pc_inc;
        next_taken = 1'b0;
        next_err   = 1'b0;
        if (stall) begin
            next_pc = pc;
        end else if (branch) begin
            if (rd.valid) begin
                next_taken = 1'b1;
                next_pc    = rd.abs ? rd.target : pc_rel;
            end else begin
                next_err = 1'b1;    // fall through on an unwritten entry
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            taken <= 1'b0;
            err   <= 1'b0;
        end else begin
            pc    <= next_pc;
            taken <= next_taken;
            err   <= next_err;
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
module tb_branch_target_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_target;
    logic        wr_abs;
    logic        stall;
    logic        branch;
    logic [3:0]  lut_addr;
    logic [11:0] pc;
    logic        taken;
    logic        err;

    branch_target_unit #(.D(12), .A(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_target (wr_target),
        .wr_abs    (wr_abs),
        .stall     (stall),
        .branch    (branch),
        .lut_addr  (lut_addr),
        .pc        (pc),
        .taken     (taken),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: table as plain integer arrays, pc as an integer.
    int m_target [16];
    bit m_abs    [16];
    bit m_valid  [16];
    int m_pc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_valid[k] = 0;
        m_pc = 0;
    endtask

    // One clock cycle: drive inputs, predict from the pre-edge model state,
    // then compare pc/taken/err just after the edge.
    task automatic cyc(input string tag, input bit we, input int wa, input int wt,
                       input bit wab, input bit st, input bit br, input int la);
        int npc, off;
        bit et, ee;
        wr_en = we; wr_addr = 4'(wa); wr_target = 12'(wt); wr_abs = wab;
        stall = st; branch = br; lut_addr = 4'(la);
        et = 0; ee = 0;
        if (st) begin
            npc = m_pc;
        end else if (br && m_valid[la]) begin
            et = 1;
            if (m_abs[la]) npc = m_target[la];
            else begin
                off = (m_target[la] >= 2048) ? m_target[la] - 4096 : m_target[la];
                npc = (((m_pc + off) % 4096) + 4096) % 4096;
            end
        end else begin
            ee  = br;
            npc = (m_pc + 1) % 4096;
        end
        @(posedge clk);
        if (we) begin
            m_target[wa] = wt % 4096;
            m_abs[wa]    = wab;
            m_valid[wa]  = 1;
        end
        m_pc = npc;
        #1;
        chk({tag, ".pc"},    int'(pc),    npc);
        chk({tag, ".taken"}, int'(taken), int'(et));
        chk({tag, ".err"},   int'(err),   int'(ee));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".pc"},    int'(pc),    0);
        chk({tag, ".taken"}, int'(taken), 0);
        chk({tag, ".err"},   int'(err),   0);
        wr_en = 0; branch = 0; stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_target = 0; wr_abs = 0;
        stall = 0; branch = 0; lut_addr = 0;
        model_reset();
        #2;
        chk("reset.pc", int'(pc), 0);
        chk("reset.taken", int'(taken), 0);
        chk("reset.err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run 1..5
        for (int k = 0; k < 5; k++) idle("freerun");

        // Wrap: reach 4095 via absolute entry 15, then increment to 0
        cyc("wr15", 1, 15, 4095, 1, 0, 0, 0);
        cyc("br15", 0, 0, 0, 0, 0, 1, 15);
        idle("wrap");

        // Relative -24 from pc=100
        cyc("wr3", 1, 3, 100, 1, 0, 0, 0);
        cyc("wr1", 1, 1, 12'hFE8, 0, 0, 0, 0);
        cyc("to100", 0, 0, 0, 0, 0, 1, 3);
        cyc("rel_neg", 0, 0, 0, 0, 0, 1, 1);
        idle("taken_drop");

        // Absolute 133 from pc=7, then relative 15 from 133 (rewritten in the
        // same cycle as the first branch, which must still see absolute 133)
        cyc("wr0", 1, 0, 133, 1, 0, 0, 0);
        cyc("wr4", 1, 4, 7, 1, 0, 0, 0);
        cyc("to7", 0, 0, 0, 0, 0, 1, 4);
        cyc("abs133", 1, 0, 15, 0, 0, 1, 0);
        cyc("rel15", 0, 0, 0, 0, 0, 1, 0);

        // Same-cycle write/branch on entry 2
        cyc("wr2", 1, 2, 56, 0, 0, 0, 0);
        cyc("wr5", 1, 5, 10, 1, 0, 0, 0);
        cyc("to10", 0, 0, 0, 0, 0, 1, 5);
        cyc("rbw_old", 1, 2, 60, 1, 0, 1, 2);
        cyc("rbw_new", 0, 0, 0, 0, 0, 1, 2);

        // Stall with branch for 3 cycles at pc=20
        cyc("wr6", 1, 6, 20, 1, 0, 0, 0);
        cyc("to20", 0, 0, 0, 0, 0, 1, 6);
        for (int k = 0; k < 3; k++) cyc("stall", 0, 0, 0, 0, 1, 1, 6);
        idle("unstall");

        // Mid-stream reset, then branch to unwritten entry 10 at pc=3
        mid_reset("rst_mid");
        for (int k = 0; k < 3; k++) idle("post_rst");
        cyc("br_invalid", 0, 0, 0, 0, 0, 1, 10);
        cyc("br_cleared", 0, 0, 0, 0, 0, 1, 6);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
            cyc("rnd",
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Program-counter stage with a runtime-writable branch target table. Holds the PC register and a DEPTH-entry table of D-bit targets, each tagged relative (signed offset added to PC) or absolute. On a branch request it indexes the table and loads the next PC; otherwise it increments or holds. Sits between instruction decode, which supplies the branch request and table index, and instruction memory, which is addressed by `pc`. Targets are loaded by the boot/config path.

## Interface
Parameters:
- `D`, 12, PC and target width in bits
- `A`, 4, table index width; DEPTH = 2**A entries

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  A  table entry to write
- `wr_target`  in  D  target value: two's-complement offset, or absolute address
- `wr_abs`  in  1  entry mode: 1 = absolute, 0 = relative
- `stall`  in  1  hold PC this cycle
- `branch`  in  1  take branch through table this cycle
- `lut_addr`  in  A  table index used when `branch`=1
- `pc`  out  D  current program counter (registered)
- `taken`  out  1  registered; 1 for the cycle after a branch was applied
- `err`  out  1  registered; 1 for the cycle after a branch hit an unwritten entry

## Operation
- Storage per entry: `target[D-1:0]`, `abs`, `valid`. Only `valid` is reset. `target` and `abs` need no reset.
- Write: on a rising edge with `wr_en`=1, the entry at `wr_addr` gets `target`=`wr_target`, `abs`=`wr_abs`, `valid`=1. Writes are independent of `stall`. A later write to the same entry overwrites it.
- Next-PC selection, in priority order:
  - `stall`=1: `pc` is held. `branch` is ignored, and `taken`/`err` go to 0.
  - `branch`=1 with entry valid and abs=1: `pc` <= target.
  - `branch`=1 with entry valid and abs=0: `pc` <= (pc + target) mod 2**D. `target` is treated as signed, so an all-ones value gives pc-1.
  - `branch`=1 with entry invalid: `pc` <= pc+1 (fall-through). The `err` flag is set.
  - Otherwise: `pc` <= (pc + 1) mod 2**D.
- `taken` <= `branch` & ~`stall` & valid(entry).
- `err` <= `branch` & ~`stall` & ~valid(entry).
- All arithmetic is D bits wide, and carry-out is discarded. Wrap-around is normal behaviour, not an error.
- Same-cycle write and branch to the same entry: the branch uses the pre-write contents (read-before-write). The new value is seen from the next cycle on.
- Reset (asynchronous, at any time including mid-operation): `pc`=0, `taken`=0, `err`=0, all `valid`=0. A write or branch in the reset-release cycle is not required to take effect.

## Timing
- The table read is combinational from `lut_addr` into the next-PC mux. `pc` updates on the rising edge after `branch` is sampled, so branch latency is 1 cycle.
- `taken`/`err` are aligned with the new `pc` value: both update on the same edge.
- A write takes effect on its edge. A branch in the following cycle sees the new entry, so write-to-use latency is 1 cycle.
- No handshake beyond `stall`. `stall` may stay asserted for any number of cycles, and `pc` stays constant throughout.
- Outputs after reset deassertion: `pc`=0, `taken`=0, `err`=0 until the first active edge.

## Test plan
- Reset then 5 free-run cycles, no branch: `pc` steps 0,1,2,3,4,5. With D=12, preload PC to 4095 and apply one more increment: `pc`=0, `err`=0.
- Write entry 1 = relative -24 (`wr_target`=12'hFE8). At pc=100 assert `branch`, `lut_addr`=1: next `pc`=76, `taken`=1 for 1 cycle.
- Write entry 0 = absolute 133. Branch to entry 0 from pc=7: `pc`=133. Then write entry 0 = relative 15 and branch from pc=133: `pc`=148.
- After reset, branch to unwritten entry 10 at pc=3: `pc`=4, `err`=1, `taken`=0.
- Same-cycle write and branch on entry 2: entry 2 holds relative 56, write absolute 60 in the same cycle, branch from pc=10: `pc`=66. Branch again on entry 2 from pc=66: `pc`=60.
- Assert `stall` together with `branch` for 3 cycles at pc=20: `pc` stays 20 and `taken`=0 throughout. Assert `rst_n`=0 mid-stream: `pc`, `taken`, `err` go to 0 immediately, and a subsequent branch to any entry sets `err`.
